ex_madd: RTL and testbench
==========================

EX_MADD -- requirements
Module: ex_madd

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port stall, input, 6 bits: pipeline stall vector from ctrl; bit 4 = EX/MEM register held.
REQ-004 SHALL have port flush, input, 1 bit: pipeline flush; abandons any operation in progress.
REQ-005 SHALL have port start, input, 1 bit: EX stage holds a multiply-accumulate instruction.
REQ-006 SHALL have port op, input, 2 bits: 00 MADDU, 01 MADD, 10 MSUBU, 11 MSUB.
REQ-007 SHALL have ports opa and opb, input, 32 bits each: multiplicand and multiplier.
REQ-008 SHALL have ports hi_in and lo_in, input, 32 bits each: current HI/LO, forwarded from the later stages.
REQ-009 SHALL have port stallreq, output, 1 bit: request to ctrl to hold EX and earlier stages.
REQ-010 SHALL have port whilo, output, 1 bit: HI/LO write enable toward the EX/MEM register.
REQ-011 SHALL have ports hi_out and lo_out, output, 32 bits each: accumulated result.

Function
REQ-012 SHALL implement the FSM states IDLE, MUL, ACC and DONE.
REQ-013 IDLE, with start=1 and flush=0: SHALL capture opa, opb and op, then go to MUL; otherwise it SHALL stay in IDLE.
REQ-014 MUL: SHALL register the 64-bit product of the captured operands, then go to ACC.
  - op[0]=1: two's-complement signed multiply.
  - op[0]=0: unsigned multiply.
REQ-015 ACC: SHALL sample hi_in/lo_in in this cycle, register the 64-bit result, then go to DONE.
  - op[1]=0: result = {hi_in,lo_in} + product.
  - op[1]=1: result = {hi_in,lo_in} - product.
  - Arithmetic is modulo 2^64; no overflow flag.
REQ-016 DONE, with stall[4]=0: SHALL go to IDLE on the next edge (the EX/MEM register captures the result on that edge).
REQ-017 DONE, with stall[4]=1: SHALL stay in DONE, holding whilo, hi_out and lo_out stable.
REQ-018 stallreq SHALL be combinational: 1 when (IDLE and start) or in MUL or in ACC; 0 in DONE.
REQ-019 whilo SHALL be 1 exactly while the state is DONE.
REQ-020 hi_out/lo_out SHALL drive the registered result; their value outside DONE is don't-care but SHALL be deterministic.
REQ-021 Latency: start seen in IDLE at cycle N gives MUL at N+1, ACC at N+2, DONE at N+3; stallreq is high in cycles N..N+2.
REQ-022 start asserted while in MUL, ACC or DONE SHALL be ignored; the next operation SHALL only be accepted from IDLE.
REQ-023 flush=1 in any state:
  - next state SHALL be IDLE;
  - stallreq SHALL be forced to 0 in that cycle;
  - whilo SHALL be forced to 0 in that cycle.
REQ-024 flush SHALL have priority over start and over stall[4].
REQ-025 stall bits other than bit 4 SHALL NOT affect the FSM (EX holding is what stallreq itself produces).

Reset
REQ-026 reset=1 SHALL asynchronously force:
  - state IDLE;
  - captured operands, op, product and result registers to 0;
  - hence whilo=0, hi_out=0, lo_out=0, and stallreq=start.
REQ-027 reset asserted mid-operation (MUL, ACC or DONE) SHALL discard the operation with no whilo pulse.
  - The first accepted start after reset deassertion SHALL behave per REQ-021.

Verification
REQ-028 MADD: op=01, opa=3, opb=0xFFFFFFFE (-2), hi_in:lo_in=0:10 -> at N+3 whilo=1, hi_out=0, lo_out=4; stallreq high for exactly 3 cycles.
REQ-029 MADDU: op=00, opa=opb=0xFFFFFFFF, HI/LO=0 -> hi_out=0xFFFFFFFE, lo_out=0x00000001.
REQ-030 MSUB: op=11, opa=1, opb=1, HI/LO=0 -> hi_out=lo_out=0xFFFFFFFF (wrap); also MSUBU with the same operands gives the same result.
REQ-031 Flush: flush=1 in the ACC cycle -> IDLE next cycle, whilo never asserted, stallreq=0 in the flush cycle; a new start two cycles later completes normally.
REQ-032 Hold: stall[4]=1 for 2 cycles after DONE is entered -> whilo=1 and hi/lo stable for 3 cycles, then IDLE.
REQ-033 Reset: reset pulsed in MUL -> outputs 0 immediately, state IDLE; start held during reset -> stallreq follows start; the operation is accepted on the first edge after release.

Source files
------------

// File: rtl/ex_madd_if.sv
// Bus between the EX-stage multiply-accumulate unit and the pipeline around it:
// stall/flush control from ctrl, the instruction operands, forwarded HI/LO, and
// the stall request plus HI/LO write-back toward EX/MEM.
interface ex_madd_if;
  logic [5:0]  stall;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        stallreq;
  logic        whilo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  // Pipeline / ctrl side
  modport master (
    output stall, flush, start, op, opa, opb, hi_in, lo_in,
    input  stallreq, whilo, hi_out, lo_out
  );

  // Multiply-accumulate unit side
  modport slave (
    input  stall, flush, start, op, opa, opb, hi_in, lo_in,
    output stallreq, whilo, hi_out, lo_out
  );
endinterface

// File: rtl/ex_madd.sv
// Multi-cycle MADD/MADDU/MSUB/MSUBU unit for the EX stage.
// IDLE captures the operands, MUL forms the 64-bit product, ACC combines it with
// the forwarded HI/LO, DONE presents the result until EX/MEM takes it.
module ex_madd (
  input  logic       clk,
  input  logic       reset,
  ex_madd_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [1:0]  op_q;
  logic [63:0] prod_q;
  logic [63:0] res_q;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] acc_in;
  logic [63:0] prod_d;
  logic [63:0] res_d;

  // Only bit 4 (EX/MEM hold) matters here; the rest of the vector is unused.
  logic unused_stall;
  assign unused_stall = ^{bus.stall[5], bus.stall[3:0]};

  // Product and accumulate datapath. Operands are extended to 64 bits according
  // to signedness, so a truncated 64x64 multiply gives the exact 64-bit product
  // for both signed and unsigned forms.
  always_comb begin
    ext_a  = op_q[0] ? {{32{opa_q[31]}}, opa_q} : {32'd0, opa_q};
    ext_b  = op_q[0] ? {{32{opb_q[31]}}, opb_q} : {32'd0, opb_q};
    prod_d = ext_a * ext_b;
    acc_in = {bus.hi_in, bus.lo_in};
    res_d  = op_q[1] ? (acc_in - prod_q) : (acc_in + prod_q);
  end

  // Sequencer: flush abandons work from any state and beats both start and the
  // EX/MEM hold; start is only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      op_q    <= 2'd0;
      prod_q  <= 64'd0;
      res_q   <= 64'd0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opa_q   <= bus.opa;
            opb_q   <= bus.opb;
            op_q    <= bus.op;
            state_q <= MUL;
          end
        end
        MUL: begin
          prod_q  <= prod_d;
          state_q <= ACC;
        end
        ACC: begin
          res_q   <= res_d;
          state_q <= DONE;
        end
        DONE: begin
          if (!bus.stall[4]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold the front of the pipeline from the cycle start is seen until the
  // result is ready; a flush cancels the request in the same cycle.
  assign bus.stallreq = ~bus.flush &
                        (((state_q == IDLE) & bus.start) |
                         (state_q == MUL) | (state_q == ACC));

  // HI/LO write strobe for as long as the result is being offered.
  assign bus.whilo  = ~bus.flush & (state_q == DONE);
  assign bus.hi_out = res_q[63:32];
  assign bus.lo_out = res_q[31:0];

endmodule

// File: tb/tb_ex_madd.sv
// Testbench for ex_madd: directed MADD/MADDU/MSUB/MSUBU vectors, hold, flush
// and reset cases. Expected results are queued at issue time and a monitor
// compares them when the unit presents a write that EX/MEM would capture.
module tb_ex_madd;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ex_madd_if bus ();

  ex_madd dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a write is consumed when whilo is high and EX/MEM is not held.
  always @(negedge clk) begin
    logic [63:0] exp_v;
    if (!reset && bus.whilo && !bus.stall[4]) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_whilo: got hi=%h lo=%h, expected no write",
                 bus.hi_out, bus.lo_out);
      end else begin
        exp_v = sb_q.pop_front();
        chk("sb_result", {bus.hi_out, bus.lo_out}, exp_v);
        $display("[TB] txn hi=%h lo=%h (expected %h)", bus.hi_out, bus.lo_out, exp_v);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  // One complete operation. hold = cycles stall[4] stays high after DONE entry;
  // noise = other stall bits driven throughout; release_rst drops reset as start
  // is issued.
  task automatic do_op(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic [63:0] exp, input int hold,
                       input logic [5:0] noise, input bit release_rst);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    bus.hi_in = 32'hDEADBEEF;
    bus.lo_in = 32'h12345678;
    bus.stall = noise & 6'b101111;
    if (release_rst) reset = 1'b0;
    sb_q.push_back(exp);
    @(negedge clk); chk({name, "_stallreq_idle"}, bus.stallreq, 1);
    // MUL: start held and operands changed, both must be ignored
    @(posedge clk); #1;
    bus.opa = ~a;
    bus.opb = ~b;
    bus.op  = ~op;
    @(negedge clk); chk({name, "_stallreq_mul"}, bus.stallreq, 1);
    // ACC: the real HI/LO is only present in this cycle
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_in = hi;
    bus.lo_in = lo;
    @(negedge clk); chk({name, "_stallreq_acc"}, bus.stallreq, 1);
    // DONE
    @(posedge clk); #1;
    bus.hi_in = 32'hDEADBEEF;
    bus.lo_in = 32'h12345678;
    bus.stall = (hold > 0) ? (noise | 6'b010000) : (noise & 6'b101111);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk({name, "_whilo_done"}, bus.whilo, 1);
      chk({name, "_stallreq_done"}, bus.stallreq, 0);
      if (hold > 0) chk({name, "_hold_hilo"}, {bus.hi_out, bus.lo_out}, exp);
      @(posedge clk); #1;
      if (i + 1 >= hold) bus.stall = noise & 6'b101111;
    end
    @(negedge clk); chk({name, "_whilo_after"}, bus.whilo, 0);
    bus.stall = 6'd0;
  endtask

  // Operation abandoned by a flush k cycles after start (0=IDLE .. 3=DONE held).
  task automatic flush_op(input int k);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.opa   = 32'd5;
    bus.opb   = 32'd6;
    bus.stall = 6'b010000;
    for (int c = 0; c <= k; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      if (c == k) bus.flush = 1'b1;
      @(negedge clk);
      if (c == k) begin
        chk($sformatf("flush%0d_stallreq", k), bus.stallreq, 0);
        chk($sformatf("flush%0d_whilo", k), bus.whilo, 0);
      end else if (c < 3) begin
        chk($sformatf("flush%0d_pre_stallreq", k), bus.stallreq, 1);
      end
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.stall = 6'd0;
    @(negedge clk);
    chk($sformatf("flush%0d_idle_whilo", k), bus.whilo, 0);
    chk($sformatf("flush%0d_idle_stallreq", k), bus.stallreq, 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.stall = 6'd0;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.opa   = 32'd0;
    bus.opb   = 32'd0;
    bus.hi_in = 32'd0;
    bus.lo_in = 32'd0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_whilo", bus.whilo, 0);
    chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("rst_stallreq0", bus.stallreq, 0);
    bus.start = 1'b1;
    #1 chk("rst_stallreq1", bus.stallreq, 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Arithmetic vectors
    do_op("madd",   2'b01, 32'd3,        32'hFFFFFFFE, 32'd0, 32'd10,
          64'h0000000000000004, 0, 6'd0, 1'b0);
    do_op("maddu",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0,
          64'hFFFFFFFE00000001, 0, 6'd0, 1'b0);
    do_op("msub",   2'b11, 32'd1,        32'd1,        32'd0, 32'd0,
          64'hFFFFFFFFFFFFFFFF, 0, 6'd0, 1'b0);
    do_op("msubu",  2'b10, 32'd1,        32'd1,        32'd0, 32'd0,
          64'hFFFFFFFFFFFFFFFF, 0, 6'b101111, 1'b0);
    do_op("madd_wrap", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
          64'h0000000000000000, 0, 6'd0, 1'b0);
    do_op("maddu_wrap", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
          64'hFFFFFFFE00000000, 0, 6'd0, 1'b0);
    do_op("msub_neg", 2'b11, 32'h80000000, 32'd2, 32'd5, 32'd7,
          64'h0000000600000007, 0, 6'd0, 1'b0);
    do_op("msubu_big", 2'b10, 32'h80000000, 32'd2, 32'd5, 32'd7,
          64'h0000000400000007, 0, 6'b100001, 1'b0);

    // EX/MEM hold for two cycles after DONE
    do_op("hold", 2'b00, 32'h00010000, 32'h00010000, 32'd0, 32'hFFFFFFFF,
          64'h00000001FFFFFFFF, 2, 6'd0, 1'b0);

    // Flushes, then a normal operation starting two cycles after the flush
    flush_op(2);
    do_op("post_flush", 2'b01, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd100,
          64'h0000000000000060, 0, 6'd0, 1'b0);
    flush_op(0);
    flush_op(1);
    flush_op(3);

    // Reset in MUL: operation discarded, outputs cleared at once
    do_op("pre_rst", 2'b10, 32'd1, 32'd1, 32'd5, 32'd7,
          64'h0000000500000006, 0, 6'd0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.opa   = 32'd7;
    bus.opb   = 32'd9;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mul_whilo", bus.whilo, 0);
    chk("rst_mul_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("rst_mul_stallreq_start1", bus.stallreq, 1);
    bus.start = 1'b0;
    #1 chk("rst_mul_stallreq_start0", bus.stallreq, 0);
    bus.start = 1'b1;
    @(negedge clk); chk("rst_hold_whilo", bus.whilo, 0);
    do_op("after_rst", 2'b01, 32'd7, 32'd9, 32'd0, 32'd1,
          64'h0000000000000040, 0, 6'd0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
